nqueen_engine: RTL and testbench
================================

NQUEEN_ENGINE -- requirements
Module: nqueen_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both are named as in the rest of the codebase (clk, reset).
REQ-002 Parameter N, default 8, is the board size; legal range is 4..12.
REQ-003 Parameter CNT_W, default 16, is the width of the solution counter.
REQ-004 Local constant COL_W = clog2(N) is the width of a column/row index.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  pulse that begins a search; sampled in IDLE only.
REQ-008 find_all  input  1  sampled with start: 1 = enumerate all solutions, 0 = stop after the first.
REQ-009 abort  input  1  terminates the search; the block returns to IDLE with no done pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle pulse when the search is exhausted or complete.
REQ-012 sol_valid  output  1  a solution beat is presented.
REQ-013 sol_ready  input  1  consumer accepts the beat.
REQ-014 sol_row  output  N  one-hot queen position for the current row; bit c set means column c; zero when sol_valid=0.
REQ-015 sol_last  output  1  marks the beat for row N-1.
REQ-016 sol_count  output  CNT_W  number of solutions fully emitted since start; saturates at all-ones.

Function
REQ-017 State: col[0..N-1] (COL_W bits each), row pointer r, check pointer k, beat index b, registered mode bit.
REQ-018 FSM states are IDLE, CHECK, ACCEPT, NEXT, EMIT and DONE.
REQ-019 IDLE, start=1: r=0, col[0]=0, k=0, sol_count=0, mode latched; go to CHECK. start is ignored outside IDLE.
REQ-020 CHECK, one comparison per cycle: if k==r, go to ACCEPT; else if (r,col[r]) and (k,col[k]) conflict, go to NEXT; else k++.
REQ-021 Conflict means equal columns, or |r-k| == |col[r]-col[k]|, computed at COL_W+1 bits unsigned-safe.
REQ-022 ACCEPT: if r==N-1, b=0 and go to EMIT; else r++, col[r+1]=0, k=0 and go to CHECK.
REQ-023 NEXT: if col[r]<N-1, col[r]++, k=0 and go to CHECK; else if r==0, go to DONE; else r-- and stay in NEXT (backtrack).
REQ-024 EMIT: sol_valid=1, sol_row=onehot(col[b]), sol_last=(b==N-1); sol_row and sol_last stay stable while sol_ready=0.
REQ-025 EMIT handshake (sol_valid&&sol_ready): b++. On the last beat, sol_count++ (saturating); then go to NEXT with r=N-1 if mode=1, otherwise go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; sol_count holds until the next start.
REQ-027 abort has priority over every transition except reset: the next state is IDLE, sol_valid drops the next cycle, and sol_count holds.
REQ-028 Solutions are emitted in lexicographic order of (col[0],...,col[N-1]).

Reset
REQ-029 reset SHALL force: state=IDLE, busy=0, done=0, sol_valid=0, sol_row=0, sol_last=0, sol_count=0, and all of col, r, k, b to 0.
REQ-030 Reset mid-search or mid-EMIT takes effect on the same edge; no partial beat is presented afterwards.

Structure
REQ-031 Package nqueen_pkg SHALL hold the FSM state enum and the clog2-based width helper.
REQ-032 Sub-module queen_conflict: combinational, takes two (row,col) pairs and returns conflict; instantiated once.
REQ-033 The col array is a flat register file; no memory macro is used.

Verification
REQ-034 N=4, find_all=1, sol_ready=1 -> 2 solutions: (1,3,0,2) then (2,0,3,1); sol_count=2; done pulses once.
REQ-035 N=8, find_all=0 -> a single solution (0,4,7,5,2,6,1,3); sol_count=1; then done.
REQ-036 N=8, find_all=1 -> 92 solutions, the last being (7,3,0,2,5,1,6,4); sol_count=92.
REQ-037 N=6, find_all=1, sol_ready low for 5 cycles on beat 2 -> sol_row is held stable; 4 solutions total.
REQ-038 N=8, abort asserted during the 3rd EMIT -> IDLE next cycle; done never pulses; sol_count=2.
REQ-039 reset during CHECK, then start with N=4 -> the first solution is again (1,3,0,2).

Source files
------------

// File: rtl/nqueen_pkg.sv
// nqueen_pkg: search FSM encoding and index-width helper shared by the
// N-queens engine and its conflict checker.
package nqueen_pkg;

  // Backtracking search states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ACCEPT = 3'd2,
    ST_NEXT   = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Smallest width w (at least 1) such that 2**w >= value.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/queen_conflict.sv
// queen_conflict: combinational attack test between two queens given as
// (row, col) pairs. Differences are taken one bit wider than the indices so
// the absolute-value subtraction can never wrap.
module queen_conflict
  import nqueen_pkg::*;
#(
  parameter int COL_W = 3
) (
  input  logic [COL_W-1:0] row_a,
  input  logic [COL_W-1:0] col_a,
  input  logic [COL_W-1:0] row_b,
  input  logic [COL_W-1:0] col_b,
  output logic             conflict
);

  logic [COL_W:0] row_diff;
  logic [COL_W:0] col_diff;

  // Same column, or same diagonal (|dr| == |dc|), means the queens attack.
  always_comb begin
    row_diff = (row_a >= row_b) ? ({1'b0, row_a} - {1'b0, row_b})
                                : ({1'b0, row_b} - {1'b0, row_a});
    col_diff = (col_a >= col_b) ? ({1'b0, col_a} - {1'b0, col_b})
                                : ({1'b0, col_b} - {1'b0, col_a});
    conflict = (col_a == col_b) || (row_diff == col_diff);
  end

endmodule

// File: rtl/nqueen_engine.sv
// nqueen_engine: iterative backtracking N-queens solver. One queen-pair
// comparison per cycle; each solution is streamed as N one-hot row beats
// over a valid/ready handshake, in lexicographic column order.
module nqueen_engine
  import nqueen_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             find_all,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sol_valid,
  input  logic             sol_ready,
  output logic [N-1:0]     sol_row,
  output logic             sol_last,
  output logic [CNT_W-1:0] sol_count
);

  localparam int COL_W = clog2(N);
  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(N - 1);

  state_t           state_reg;
  logic [COL_W-1:0] r_reg;
  logic [COL_W-1:0] k_reg;
  logic [COL_W-1:0] b_reg;
  logic             mode_reg;

  // Column of the queen placed on each row; one register per row.
  logic [COL_W-1:0] col_reg [N];

  logic [COL_W-1:0] col_r;
  logic [COL_W-1:0] col_k;
  logic [COL_W-1:0] r_inc;
  logic [COL_W-1:0] k_inc;
  logic [COL_W-1:0] b_inc;
  logic             conflict;

  // Single write port into the column register file.
  logic             col_we;
  logic [COL_W-1:0] col_waddr;
  logic [COL_W-1:0] col_wdata;

  assign col_r = col_reg[r_reg];
  assign col_k = col_reg[k_reg];
  assign r_inc = r_reg + 1'b1;
  assign k_inc = k_reg + 1'b1;
  assign b_inc = b_reg + 1'b1;

  function automatic logic [N-1:0] onehot(input logic [COL_W-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  queen_conflict #(
    .COL_W (COL_W)
  ) u_conflict (
    .row_a    (r_reg),
    .col_a    (col_r),
    .row_b    (k_reg),
    .col_b    (col_k),
    .conflict (conflict)
  );

  // Column write decode: clear the new row on start/advance, bump on retry.
  always_comb begin
    col_we    = 1'b0;
    col_waddr = '0;
    col_wdata = '0;
    if (!abort) begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            col_we    = 1'b1;
            col_waddr = '0;
            col_wdata = '0;
          end
        end
        ST_ACCEPT: begin
          if (r_reg != LAST_IDX) begin
            col_we    = 1'b1;
            col_waddr = r_inc;
            col_wdata = '0;
          end
        end
        ST_NEXT: begin
          if (col_r < LAST_IDX) begin
            col_we    = 1'b1;
            col_waddr = r_reg;
            col_wdata = col_r + 1'b1;
          end
        end
        default: begin
          col_we = 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    logic [COL_W-1:0] col_q;

    // Row gi column register, loaded through the shared write port.
    always_ff @(posedge clk) begin
      if (reset) begin
        col_q <= '0;
      end else if (col_we && (col_waddr == COL_W'(gi))) begin
        col_q <= col_wdata;
      end
    end

    assign col_reg[gi] = col_q;
  end

  // Search FSM with registered status and stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      r_reg     <= '0;
      k_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sol_valid <= 1'b0;
      sol_row   <= '0;
      sol_last  <= 1'b0;
      sol_count <= '0;
    end else if (abort) begin
      // Abort wins over everything but reset; the count is left as is.
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sol_valid <= 1'b0;
      sol_row   <= '0;
      sol_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            r_reg     <= '0;
            k_reg     <= '0;
            sol_count <= '0;
            mode_reg  <= find_all;
            busy      <= 1'b1;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (k_reg == r_reg) begin
            state_reg <= ST_ACCEPT;
          end else if (conflict) begin
            state_reg <= ST_NEXT;
          end else begin
            k_reg <= k_inc;
          end
        end
        ST_ACCEPT: begin
          if (r_reg == LAST_IDX) begin
            b_reg     <= '0;
            sol_valid <= 1'b1;
            sol_row   <= onehot(col_reg[0]);
            sol_last  <= 1'b0;
            state_reg <= ST_EMIT;
          end else begin
            r_reg     <= r_inc;
            k_reg     <= '0;
            state_reg <= ST_CHECK;
          end
        end
        ST_NEXT: begin
          if (col_r < LAST_IDX) begin
            k_reg     <= '0;
            state_reg <= ST_CHECK;
          end else if (r_reg == '0) begin
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            r_reg <= r_reg - 1'b1;
          end
        end
        ST_EMIT: begin
          if (sol_ready) begin
            if (b_reg == LAST_IDX) begin
              if (sol_count != {CNT_W{1'b1}}) sol_count <= sol_count + 1'b1;
              sol_valid <= 1'b0;
              sol_row   <= '0;
              sol_last  <= 1'b0;
              if (mode_reg) begin
                r_reg     <= LAST_IDX;
                state_reg <= ST_NEXT;
              end else begin
                done      <= 1'b1;
                state_reg <= ST_DONE;
              end
            end else begin
              b_reg    <= b_inc;
              sol_row  <= onehot(col_reg[b_inc]);
              sol_last <= (b_inc == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nqueen_engine.sv
// tb_nqueen_engine: directed table-driven bench for the N-queens engine,
// with engines for N=4, 6 and 8 side by side and one selected at a time.
module tb_nqueen_engine;

  localparam int CNT_W  = 16;
  localparam int BUDGET = 150000;

  logic clk;
  logic reset;
  logic find_all;
  logic abort;
  logic sol_ready;
  logic [2:0] start_v;

  logic busy4, done4, valid4, last4;
  logic [3:0] row4;
  logic [CNT_W-1:0] count4;
  logic busy6, done6, valid6, last6;
  logic [5:0] row6;
  logic [CNT_W-1:0] count6;
  logic busy8, done8, valid8, last8;
  logic [7:0] row8;
  logic [CNT_W-1:0] count8;

  nqueen_engine #(.N(4), .CNT_W(CNT_W)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .find_all(find_all), .abort(abort),
    .busy(busy4), .done(done4), .sol_valid(valid4), .sol_ready(sol_ready),
    .sol_row(row4), .sol_last(last4), .sol_count(count4)
  );

  nqueen_engine #(.N(6), .CNT_W(CNT_W)) u_dut6 (
    .clk(clk), .reset(reset), .start(start_v[1]), .find_all(find_all), .abort(abort),
    .busy(busy6), .done(done6), .sol_valid(valid6), .sol_ready(sol_ready),
    .sol_row(row6), .sol_last(last6), .sol_count(count6)
  );

  nqueen_engine #(.N(8), .CNT_W(CNT_W)) u_dut8 (
    .clk(clk), .reset(reset), .start(start_v[2]), .find_all(find_all), .abort(abort),
    .busy(busy8), .done(done8), .sol_valid(valid8), .sol_ready(sol_ready),
    .sol_row(row8), .sol_last(last8), .sol_count(count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int sel;
  logic m_busy, m_done, m_valid, m_last;
  logic [11:0] m_row;
  logic [CNT_W-1:0] m_count;

  // Route the selected engine's outputs onto common observation signals.
  always_comb begin
    m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_last = 1'b0;
    m_row = '0; m_count = '0;
    case (sel)
      0: begin m_busy = busy4; m_done = done4; m_valid = valid4; m_last = last4;
               m_row = 12'(row4); m_count = count4; end
      1: begin m_busy = busy6; m_done = done6; m_valid = valid6; m_last = last6;
               m_row = 12'(row6); m_count = count6; end
      default: begin m_busy = busy8; m_done = done8; m_valid = valid8; m_last = last8;
               m_row = 12'(row8); m_count = count8; end
    endcase
  end

  typedef struct {
    int          sel;
    bit          mode;
    int          exp_sols;
    logic [47:0] exp_first;
    logic [47:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int failures = 0;
  logic [47:0] sols[$];
  int done_cnt, bad_beats, bad_hold, hold_seen, aborted, timed_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 6 : 8);
  endfunction

  // Column index of a one-hot row, or -1 if not exactly one legal bit.
  function automatic int row_col(input logic [11:0] row, input int n);
    int idx, cnt;
    idx = -1; cnt = 0;
    for (int i = 0; i < 12; i++) if (row[i]) begin cnt++; idx = i; end
    if (cnt != 1 || idx >= n) return -1;
    return idx;
  endfunction

  // True if the nibble-packed placement (col[0] most significant) is non-attacking.
  function automatic bit sol_ok(input logic [47:0] s, input int n);
    int c[12];
    int d;
    for (int i = 0; i < n; i++) c[i] = int'(s[4*(n-1-i) +: 4]);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < i; j++) begin
        d = (c[i] > c[j]) ? c[i] - c[j] : c[j] - c[i];
        if (c[i] == c[j] || d == i - j) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Start engine s and collect all beats until it goes idle.
  task automatic run_search(input int s, input bit mode, input int stall_beat, input int abort_sol);
    int n, beat, gbeat, cyc, c;
    logic [47:0] acc;
    logic [11:0] held;
    logic held_last;
    n = n_of(s);
    sols.delete();
    done_cnt = 0; bad_beats = 0; bad_hold = 0; hold_seen = 0; aborted = 0; timed_out = 0;
    sel = s; find_all = mode; sol_ready = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    beat = 0; gbeat = 0; acc = '0; cyc = 0;
    while (m_busy) begin
      if (m_done) done_cnt++;
      if (!m_valid && m_row != 0) bad_beats++;
      if (m_valid) begin
        if (abort_sol >= 0 && sols.size() == abort_sol && beat == 0 && aborted == 0) begin
          abort = 1'b1; aborted = 1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_valid_drop", m_valid, 1'b0);
          chk("abort_busy_low", m_busy, 1'b0);
          chk("abort_count_hold", m_count, abort_sol);
          break;
        end
        if (gbeat == stall_beat) begin
          held = m_row; held_last = m_last; sol_ready = 1'b0; hold_seen = 1;
          repeat (5) begin
            @(posedge clk); #1;
            if (!m_valid || m_row !== held || m_last !== held_last) bad_hold++;
          end
          sol_ready = 1'b1;
        end
        if (m_last !== (beat == n - 1)) bad_beats++;
        c = row_col(m_row, n);
        if (c < 0) begin bad_beats++; c = 0; end
        acc = (acc << 4) | 48'(c);
        gbeat++; beat++;
        if (beat == n) begin sols.push_back(acc); acc = '0; beat = 0; end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > BUDGET) begin timed_out = 1; break; end
    end
    repeat (4) begin
      if (m_done) done_cnt++;
      @(posedge clk); #1;
    end
  endtask

  // Compare a finished run against its expected solution list summary.
  task automatic check_run(input string tag, input int exp_sols, input logic [47:0] exp_first,
                           input logic [47:0] exp_last, input int n);
    logic [47:0] first, last;
    int bad_sols;
    first = (sols.size() > 0) ? sols[0] : '1;
    last  = (sols.size() > 0) ? sols[sols.size()-1] : '1;
    bad_sols = 0;
    for (int i = 0; i < sols.size(); i++) begin
      if (!sol_ok(sols[i], n)) bad_sols++;
      if (i > 0 && sols[i] <= sols[i-1]) bad_sols++;
    end
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_num_solutions"}, sols.size(), exp_sols);
    chk({tag, "_first"}, first, exp_first);
    chk({tag, "_last"}, last, exp_last);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_sol_count"}, m_count, exp_sols);
    chk({tag, "_beat_format"}, bad_beats, 0);
    chk({tag, "_legal_ordered"}, bad_sols, 0);
    $display("run %s n=%0d solutions=%0d sol_count=%0d done_pulses=%0d", tag, n,
             sols.size(), m_count, done_cnt);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{0, 1'b1,  2, 48'h1302,     48'h2031};
    vecs[1] = '{2, 1'b0,  1, 48'h04752613, 48'h04752613};
    vecs[2] = '{2, 1'b1, 92, 48'h04752613, 48'h73025164};
    vecs[3] = '{1, 1'b1,  4, 48'h135024,   48'h420531};
    vecs[4] = '{0, 1'b0,  1, 48'h1302,     48'h1302};
    vecs[5] = '{1, 1'b0,  1, 48'h135024,   48'h135024};

    reset = 1'b1; start_v = '0; find_all = 1'b0; abort = 1'b0; sol_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset_state", {m_busy, m_done, m_valid, m_last, m_row, m_count}, 64'd0);
      $display("reset check engine n=%0d busy=%0b count=%0d", n_of(s), m_busy, m_count);
    end
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_search(vecs[v].sel, vecs[v].mode, -1, -1);
      check_run($sformatf("vec%0d", v), vecs[v].exp_sols, vecs[v].exp_first,
                vecs[v].exp_last, n_of(vecs[v].sel));
    end

    // Back-pressure on beat 2 of the first N=6 solution.
    run_search(1, 1'b1, 2, -1);
    check_run("stall6", 4, 48'h135024, 48'h420531, 6);
    chk("stall_seen", hold_seen, 1);
    chk("stall_hold_stable", bad_hold, 0);
    $display("stall run hold_violations=%0d", bad_hold);

    // Abort on the first beat of the third N=8 solution.
    run_search(2, 1'b1, -1, 2);
    chk("abort_taken", aborted, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_num_solutions", sols.size(), 2);
    chk("abort_count_after", m_count, 2);
    $display("abort run solutions=%0d sol_count=%0d done_pulses=%0d", sols.size(), m_count, done_cnt);

    // Reset while the N=4 engine is checking row 1, then search again.
    sel = 0; find_all = 1'b1; sol_ready = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_reset", m_busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_in_check", {m_busy, m_done, m_valid, m_last, m_row, m_count}, 64'd0);
    run_search(0, 1'b1, -1, -1);
    check_run("after_reset4", 2, 48'h1302, 48'h2031, 4);

    // Reset in the middle of the second N=4 solution's stream.
    @(posedge clk); #1; start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    cyc = 0;
    while (!(m_valid && m_count == 1) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("emit2_reached", (cyc < 2000), 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_in_emit", {m_busy, m_done, m_valid, m_last, m_row, m_count}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_emit_reset", {m_busy, m_valid, m_row}, 64'd0);
    $display("reset-in-emit busy=%0b valid=%0b count=%0d", m_busy, m_valid, m_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
